// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator with registered syncs, enable, coordinates and strobes.
// Defining VGA_TESTPAT_EN adds an 8-bit RRRGGGBB colour-bar output rgb.
module vga_timing_gen #(
    parameter int H_ACT   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_ACT   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int PIX_DIV = 4,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int CW      = 10
) (
    input  logic          clk,
    input  logic          rst,
`ifdef VGA_TESTPAT_EN
    output logic [7:0]    rgb,
`endif
    output logic          req,
    output logic          en,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start
);
    localparam int HT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DW-1:0] P_END = DW'(PIX_DIV - 1);
    localparam logic [CW-1:0] H_END = CW'(HT - 1);
    localparam logic [CW-1:0] H_FS  = CW'(H_ACT);
    localparam logic [CW-1:0] H_SS  = CW'(H_ACT + H_FP);
    localparam logic [CW-1:0] H_BS  = CW'(H_ACT + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_END = CW'(VT - 1);
    localparam logic [CW-1:0] V_FS  = CW'(V_ACT);
    localparam logic [CW-1:0] V_SS  = CW'(V_ACT + V_FP);
    localparam logic [CW-1:0] V_BS  = CW'(V_ACT + V_FP + V_SYNC);

    typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} region_t;

    logic [DW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0] h_q, h_d, v_q, v_d;
    region_t       hst_q, hst_d, vst_q, vst_d;
    logic          tick, h_wrap, v_step;
    logic          req_q, req_d, en_q, en_d, hs_q, hs_d, vs_q, vs_d;
    logic          ls_q, ls_d, fs_q, fs_d;
    logic [CW-1:0] col_q, col_d, row_q, row_d;

    // Region states follow the next counter value; later boundaries win so zero-width porches are skipped.
    always_comb begin
        tick   = pcnt_q == P_END;
        h_wrap = h_q == H_END;
        v_step = tick && h_wrap;
        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        h_d    = tick ? (h_wrap ? '0 : h_q + 1'b1) : h_q;
        v_d    = v_step ? ((v_q == V_END) ? '0 : v_q + 1'b1) : v_q;
        hst_d  = !tick ? hst_q : (h_d == '0) ? ACTIVE : (h_d == H_BS) ? BP :
                 (h_d == H_SS) ? SYNC : (h_d == H_FS) ? FP : hst_q;
        vst_d  = !v_step ? vst_q : (v_d == '0) ? ACTIVE : (v_d == V_BS) ? BP :
                 (v_d == V_SS) ? SYNC : (v_d == V_FS) ? FP : vst_q;
        en_d   = hst_q == ACTIVE && vst_q == ACTIVE;
        col_d  = en_d ? h_q : '0;
        row_d  = en_d ? v_q : '0;
        hs_d   = (hst_q == SYNC) ? HS_POL : ~HS_POL;
        vs_d   = (vst_q == SYNC) ? VS_POL : ~VS_POL;
        req_d  = tick;
        ls_d   = tick && h_q == '0;
        fs_d   = ls_d && v_q == '0;
    end

`ifdef VGA_TESTPAT_EN
    localparam logic [CW+2:0] HA_W = (CW+3)'(H_ACT);
    logic [2:0] bar;
    logic [7:0] rgb_q, rgb_d;

    always_comb begin
        bar   = 3'({h_q, 3'b000} / HA_W);
        rgb_d = en_d ? {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}} : 8'h00;
    end

    assign rgb = rgb_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
            h_q    <= '0;
            v_q    <= '0;
            hst_q  <= ACTIVE;
            vst_q  <= ACTIVE;
            req_q  <= 1'b0;
            en_q   <= 1'b0;
            col_q  <= '0;
            row_q  <= '0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
`ifdef VGA_TESTPAT_EN
            rgb_q  <= 8'h00;
`endif
        end else begin
            pcnt_q <= pcnt_d;
            h_q    <= h_d;
            v_q    <= v_d;
            hst_q  <= hst_d;
            vst_q  <= vst_d;
            req_q  <= req_d;
            en_q   <= en_d;
            col_q  <= col_d;
            row_q  <= row_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
`ifdef VGA_TESTPAT_EN
            rgb_q  <= rgb_d;
`endif
        end
    end

    assign req         = req_q;
    assign en          = en_q;
    assign col         = col_q;
    assign row         = row_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three configurations checked every clk against an arithmetic timing model.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n = 0;
    int m = -1;

    logic a_req, a_en, a_hs, a_vs, a_ls, a_fs;
    logic [5:0] a_col, a_row;
    logic b_req, b_en, b_hs, b_vs, b_ls, b_fs;
    logic [5:0] b_col, b_row;
    logic c_req, c_en, c_hs, c_vs, c_ls, c_fs;
    logic [9:0] c_col, c_row;
`ifdef VGA_TESTPAT_EN
    logic [7:0] a_rgb, b_rgb, c_rgb;
`endif

    vga_timing_gen #(.H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .PIX_DIV(1), .HS_POL(1'b0), .VS_POL(1'b0), .CW(6)) dut_a (
        .clk(clk), .rst(rst),
`ifdef VGA_TESTPAT_EN
        .rgb(a_rgb),
`endif
        .req(a_req), .en(a_en), .col(a_col), .row(a_row), .hsync(a_hs), .vsync(a_vs),
        .line_start(a_ls), .frame_start(a_fs));

    vga_timing_gen #(.H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACT(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .PIX_DIV(3), .HS_POL(1'b1), .VS_POL(1'b1), .CW(6)) dut_b (
        .clk(clk), .rst(rst),
`ifdef VGA_TESTPAT_EN
        .rgb(b_rgb),
`endif
        .req(b_req), .en(b_en), .col(b_col), .row(b_row), .hsync(b_hs), .vsync(b_vs),
        .line_start(b_ls), .frame_start(b_fs));

    vga_timing_gen dut_c (
        .clk(clk), .rst(rst),
`ifdef VGA_TESTPAT_EN
        .rgb(c_rgb),
`endif
        .req(c_req), .en(c_en), .col(c_col), .row(c_row), .hsync(c_hs), .vsync(c_vs),
        .line_start(c_ls), .frame_start(c_fs));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected outputs after the k-th unreset edge come from the counter state after k-1 counting edges.
    task automatic check_dut(input string tag, input int ha, hf, hs, hb, va, vf, vs, vb, d,
                             input bit hp, vp, input int mm,
                             input logic o_req, o_en, input logic [31:0] o_col, o_row,
                             input logic o_hs, o_vs, o_ls, o_fs);
        int ht, vt, p, h, v;
        bit tk, e_en;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (mm < 0) begin
            chk({tag, ".rst.req"}, o_req, 0);
            chk({tag, ".rst.en"}, o_en, 0);
            chk({tag, ".rst.col"}, o_col, 0);
            chk({tag, ".rst.row"}, o_row, 0);
            chk({tag, ".rst.hsync"}, o_hs, !hp);
            chk({tag, ".rst.vsync"}, o_vs, !vp);
            chk({tag, ".rst.ls"}, o_ls, 0);
            chk({tag, ".rst.fs"}, o_fs, 0);
        end else begin
            tk = (mm % d) == d - 1;
            p = mm / d;
            h = p % ht;
            v = (p / ht) % vt;
            e_en = h < ha && v < va;
            chk({tag, ".req"}, o_req, tk);
            chk({tag, ".en"}, o_en, e_en);
            chk({tag, ".col"}, o_col, e_en ? h : 0);
            chk({tag, ".row"}, o_row, e_en ? v : 0);
            chk({tag, ".hsync"}, o_hs, (h >= ha + hf && h < ha + hf + hs) ? hp : !hp);
            chk({tag, ".vsync"}, o_vs, (v >= va + vf && v < va + vf + vs) ? vp : !vp);
            chk({tag, ".ls"}, o_ls, tk && h == 0);
            chk({tag, ".fs"}, o_fs, tk && h == 0 && v == 0);
        end
    endtask

`ifdef VGA_TESTPAT_EN
    task automatic check_rgb(input string tag, input int ha, va, hf, hs, hb, d, input int mm, input logic [7:0] o_rgb);
        int p, h, v, bar;
        logic [7:0] e;
        e = 8'h00;
        if (mm >= 0) begin
            p = mm / d;
            h = p % (ha + hf + hs + hb);
            v = (p / (ha + hf + hs + hb)) % (va + 4);
            bar = (h * 8) / ha;
            if (h < ha && v < va) e = {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}};
        end
        chk({tag, ".rgb"}, o_rgb, e);
    endtask
`endif

    task automatic chk_region(input string tag, input int cnt, a, f, s, st);
        chk(tag, st, cnt < a ? 0 : cnt < a + f ? 1 : cnt < a + f + s ? 2 : 3);
    endtask

    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        #1;
        m = r ? -1 : n;
        n = r ? 0 : n + 1;
        check_dut("a", 8, 2, 3, 1, 4, 1, 2, 1, 1, 1'b0, 1'b0, m, a_req, a_en, a_col, a_row, a_hs, a_vs, a_ls, a_fs);
        check_dut("b", 8, 2, 3, 1, 4, 1, 2, 1, 3, 1'b1, 1'b1, m, b_req, b_en, b_col, b_row, b_hs, b_vs, b_ls, b_fs);
        check_dut("c", 640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0, 1'b0, m, c_req, c_en, c_col, c_row, c_hs, c_vs, c_ls, c_fs);
`ifdef VGA_TESTPAT_EN
        check_rgb("a", 8, 4, 2, 3, 1, 1, m, a_rgb);
        check_rgb("b", 8, 4, 2, 3, 1, 3, m, b_rgb);
        if (m >= 0 && m < 420000) check_rgb("c", 640, 480, 16, 96, 48, 4, m, c_rgb);
`endif
        chk_region("a.hstate", int'(dut_a.h_q), 8, 2, 3, int'(dut_a.hst_q));
        chk_region("a.vstate", int'(dut_a.v_q), 4, 1, 2, int'(dut_a.vst_q));
        chk_region("b.hstate", int'(dut_b.h_q), 8, 2, 3, int'(dut_b.hst_q));
        chk_region("b.vstate", int'(dut_b.v_q), 4, 1, 2, int'(dut_b.vst_q));
    endtask

    initial begin
        int fs_n, ls_n, hs_lo, vs_lo, en_n, rq_n;
        repeat (3) step(1'b1);
        step(1'b0);
        chk("first.req", a_req, 1);
        chk("first.fs", a_fs, 1);
        chk("first.ls", a_ls, 1);
        chk("first.en", a_en, 1);
        chk("first.col", a_col, 0);
        chk("first.row", a_row, 0);
        chk("first.b_req", b_req, 0);
        repeat (36) step(1'b0);
        chk("pos.h", dut_a.h_q, 9);
        chk("pos.v", dut_a.v_q, 2);
        step(1'b1);
        chk("midrst.en", a_en, 0);
        chk("midrst.hsync", a_hs, 1);
        chk("midrst.b_hsync", b_hs, 0);
        chk("midrst.b_vsync", b_vs, 0);
        fs_n = 0; ls_n = 0; hs_lo = 0; vs_lo = 0; en_n = 0;
        for (int i = 0; i < 112; i++) begin
            step(1'b0);
            if (i == 0) chk("restart.fs", a_fs, 1);
            fs_n += int'(a_fs);
            ls_n += int'(a_ls);
            hs_lo += int'(!a_hs);
            vs_lo += int'(!a_vs);
            en_n += int'(a_en);
        end
        chk("frame.fs_count", fs_n, 1);
        chk("frame.ls_count", ls_n, 8);
        chk("frame.hsync_low", hs_lo, 24);
        chk("frame.vsync_low", vs_lo, 28);
        chk("frame.en_count", en_n, 32);
        step(1'b0);
        chk("frame.wrap_fs", a_fs, 1);
        for (int i = 0; i < 3000; i++) step($urandom_range(0, 299) == 0);
        step(1'b1);
        hs_lo = 0; ls_n = 0; rq_n = 0;
        for (int i = 0; i < 6400; i++) begin
            step(1'b0);
            if (i < 3200) hs_lo += int'(!c_hs);
            ls_n += int'(c_ls);
            rq_n += int'(c_req);
        end
        chk("vga.hsync_low", hs_lo, 384);
        chk("vga.ls_count", ls_n, 2);
        chk("vga.req_count", rq_n, 1600);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
